// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - scanned 4-digit common-anode seven-segment driver for a BCD counter chain
// Held digits are decoded per slot, with leading-zero blanking and a blank interval at each slot start.
module bcd_scan_display #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 2,
   parameter int BLANK_LZ  = 1
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [15:0] bcd_in,
   input  logic [3:0]  dp_in,
   input  logic        hold,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp_n,
   output logic        tick
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

   logic [CW-1:0] cnt;
   logic [1:0]    slot;
   logic [15:0]   hold_bcd;
   logic [3:0]    hold_dp;

   logic [3:0] zero;
   logic [3:0] lz;
   logic [3:0] digit;
   logic       blanked;
   logic [6:0] seg_dec;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         zero[i] = (hold_bcd[4*i +: 4] == 4'd0);
      end
      // a digit is leading only if it and every digit above it are zero; digit 0 always shows
      lz = 4'b0000;
      if (BLANK_LZ != 0) begin
         lz[3] = zero[3];
         lz[2] = zero[3] & zero[2];
         lz[1] = zero[3] & zero[2] & zero[1];
      end
      digit   = hold_bcd[{slot, 2'b00} +: 4];
      blanked = lz[slot];
      case (digit)
         4'd0:    seg_dec = 7'h40;
         4'd1:    seg_dec = 7'h79;
         4'd2:    seg_dec = 7'h24;
         4'd3:    seg_dec = 7'h30;
         4'd4:    seg_dec = 7'h19;
         4'd5:    seg_dec = 7'h12;
         4'd6:    seg_dec = 7'h02;
         4'd7:    seg_dec = 7'h78;
         4'd8:    seg_dec = 7'h00;
         4'd9:    seg_dec = 7'h10;
         default: seg_dec = 7'h3F;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clrn) begin
         cnt      <= '0;
         slot     <= 2'd0;
         hold_bcd <= 16'h0000;
         hold_dp  <= 4'h0;
         an       <= 4'hF;
         seg      <= 7'h7F;
         dp_n     <= 1'b1;
         tick     <= 1'b0;
      end else begin
         if (!hold) begin
            hold_bcd <= bcd_in;
            hold_dp  <= dp_in;
         end
         tick <= (cnt == CNT_MAX);
         if (cnt == CNT_MAX) begin
            cnt  <= '0;
            slot <= slot + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end
         // all anodes off at the start of each slot so the previous digit cannot ghost
         if (cnt < BLANK_END) begin
            an   <= 4'hF;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
         end else begin
            an   <= ~(4'b0001 << slot);
            seg  <= blanked ? 7'h7F : seg_dec;
            dp_n <= blanked | ~hold_dp[slot];
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - scoreboard bench for bcd_scan_display
// Two instances (leading-zero blanking on/off) share stimulus and are checked against one model.
module tb_bcd_scan_display;

   localparam int SD = 4;
   localparam int BC = 1;

   logic        clk;
   logic        clrn;
   logic [15:0] bcd_in;
   logic [3:0]  dp_in;
   logic        hold;
   logic [3:0]  an1, an0;
   logic [6:0]  seg1, seg0;
   logic        dp_n1, dp_n0;
   logic        tick1, tick0;

   bcd_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(1)) dut (
      .clk(clk), .clrn(clrn), .bcd_in(bcd_in), .dp_in(dp_in), .hold(hold),
      .an(an1), .seg(seg1), .dp_n(dp_n1), .tick(tick1)
   );

   bcd_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLANK_LZ(0)) dut_nlz (
      .clk(clk), .clrn(clrn), .bcd_in(bcd_in), .dp_in(dp_in), .hold(hold),
      .an(an0), .seg(seg0), .dp_n(dp_n0), .tick(tick0)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp_n;
      logic       tick;
      logic [6:0] seg_nlz;
      logic       dp_n_nlz;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

   // reference model: absolute position since reset plus the held digits
   int p = 0;
   int held [4] = '{0, 0, 0, 0};
   bit hdp  [4] = '{0, 0, 0, 0};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic step(input logic [15:0] b, input logic [3:0] d, input logic h, input logic r);
      exp_t e;
      @(negedge clk);
      bcd_in = b;
      dp_in  = d;
      hold   = h;
      clrn   = r;
      e = '{an: 4'hF, seg: 7'h7F, dp_n: 1'b1, tick: 1'b0, seg_nlz: 7'h7F, dp_n_nlz: 1'b1};
      if (r) begin
         p = 0;
         for (int k = 0; k < 4; k++) begin
            held[k] = 0;
            hdp[k]  = 1'b0;
         end
      end else begin
         int ph;
         int sl;
         bit lead;
         ph = p % SD;
         sl = (p / SD) % 4;
         e.tick = (ph == SD - 1);
         if (ph >= BC) begin
            lead = (sl > 0);
            for (int k = sl; k < 4; k++) if (held[k] != 0) lead = 1'b0;
            e.an[sl]   = 1'b0;
            e.seg_nlz  = dec_tab[held[sl]];
            e.dp_n_nlz = !hdp[sl];
            e.seg      = lead ? 7'h7F : e.seg_nlz;
            e.dp_n     = lead ? 1'b1 : e.dp_n_nlz;
         end
         p++;
         if (!h) begin
            for (int k = 0; k < 4; k++) begin
               held[k] = (b >> (4 * k)) & 16'hF;
               hdp[k]  = d[k];
            end
         end
      end
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("an",       {4'h0, an1},   {4'h0, e.an});
            chk("seg",      {1'b0, seg1},  {1'b0, e.seg});
            chk("dp_n",     {7'h0, dp_n1}, {7'h0, e.dp_n});
            chk("tick",     {7'h0, tick1}, {7'h0, e.tick});
            chk("an_nlz",   {4'h0, an0},   {4'h0, e.an});
            chk("seg_nlz",  {1'b0, seg0},  {1'b0, e.seg_nlz});
            chk("dp_n_nlz", {7'h0, dp_n0}, {7'h0, e.dp_n_nlz});
            chk("tick_nlz", {7'h0, tick0}, {7'h0, e.tick});
         end
      end
   end

   initial begin : stim
      logic [15:0] b;
      logic        h;
      int          guard;
      clrn   = 1'b1;
      bcd_in = 16'h0000;
      dp_in  = 4'h0;
      hold   = 1'b0;

      repeat (2) step(16'h1234, 4'h0, 1'b0, 1'b1);
      repeat (2) step(16'h1234, 4'h0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("first_digit_an",  {4'h0, an1},  8'h0E);
      chk("first_digit_seg", {1'b0, seg1}, 8'h19);
      repeat (16) step(16'h1234, 4'h0, 1'b0, 1'b0);
      repeat (16) step(16'h0070, 4'h0, 1'b0, 1'b0);
      repeat (16) step(16'h00A0, 4'b0010, 1'b0, 1'b0);
      repeat (8)  step(16'h0009, 4'h0, 1'b0, 1'b0);
      repeat (20) step(16'h0005, 4'h0, 1'b1, 1'b0);
      repeat (20) step(16'h0005, 4'h0, 1'b0, 1'b0);

      guard = 0;
      while (!(((p / SD) % 4 == 2) && (p % SD == 2)) && guard < 40) begin
         step(16'h4321, 4'h5, 1'b0, 1'b0);
         guard++;
      end
      step(16'h4321, 4'h5, 1'b0, 1'b1);
      repeat (12) step(16'h4321, 4'h5, 1'b0, 1'b0);

      h = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 4; k++) begin
            b[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 15) == 0) h = ~h;
         step(b, 4'($urandom_range(0, 15)), h, ($urandom_range(0, 199) == 0));
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 8'(q.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
